// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_INST_W = 32;
    localparam int PC_STEP    = 4;

    // HLT encoding; only acted on when FETCH_HALT_EN is defined.
    localparam logic [31:0] HLT_ENC = 32'hD440_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instruction} pairs between fetch and decode.
// Flush (and reset) take priority over push/pop; pointer wrap relies on
// DEPTH being a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [PC_W-1:0]            i_push_pc,
    input  logic [INST_W-1:0]          i_push_inst,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [PC_W-1:0]            o_head_pc,
    output logic [INST_W-1:0]          o_head_inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
            r_inst_mem[r_wr_ptr] <= i_push_inst;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_pc   = r_pc_mem[r_rd_ptr];
    assign o_head_inst = r_inst_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction
// memory under a queue-credit limit, buffers responses and hands them to
// decode. Branch redirects flush everything buffered or in flight.
// Optional build macro FETCH_HALT_EN: stop fetching after enqueuing HLT.
//
//   state  | meaning
//   IDLE   | one cycle after reset; a redirect here only reloads the PC
//   FETCH  | issuing requests whenever queue credit allows
//   HALTED | HLT enqueued, no requests until a redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] w_target;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_credit;
    logic              w_push;
    logic              w_pop;
    logic              w_is_hlt;
    logic [ADDR_W-1:0] w_head_pc;
    logic [INST_W-1:0] w_head_inst;

    // Low two target bits are masked rather than sliced off.
    assign w_target = br_target & ~ADDR_W'(3);

    // Credit counts the in-flight word so a response always finds a free slot.
    assign w_used   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit = w_used < (CW+1)'(QDEPTH);

    assign imem_req  = (r_state == FETCH) && !br_taken && w_credit;
    assign imem_addr = r_pc;

`ifdef FETCH_HALT_EN
    // Once halted, the word requested alongside HLT is dropped.
    assign w_push   = r_inflight && !br_taken && (r_state != HALTED);
    assign w_is_hlt = (imem_rdata == HLT_ENC);
    assign halted   = (r_state == HALTED);
`else
    assign w_push   = r_inflight && !br_taken;
    assign w_is_hlt = 1'b0;
    assign halted   = 1'b0;
`endif

    assign w_pop = inst_valid && inst_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   if (w_push && w_is_hlt) w_state_nxt = HALTED;
            HALTED:  if (br_taken) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    // PC, request tag and in-flight flag; redirect wins over sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) r_req_pc <= r_pc;
            if (br_taken)      r_pc <= w_target;
            else if (imem_req) r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_queue #(
        .DEPTH  (QDEPTH),
        .PC_W   (ADDR_W),
        .INST_W (INST_W)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (br_taken),
        .i_push      (w_push),
        .i_push_pc   (r_req_pc),
        .i_push_inst (imem_rdata),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst)
    );

    // Head fields read as zero whenever nothing is presented.
    assign inst_valid = (w_count != '0);
    assign inst_data  = inst_valid ? w_head_inst : '0;
    assign inst_pc    = inst_valid ? w_head_pc   : '0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 64-bit single-cycle/pipelined lab CPU. It owns the program counter, issues sequential word addresses to the instruction Memory, buffers returned instructions in a small queue, and presents them to decode with a valid/ready handshake. It applies branch redirects from execute by flushing buffered and in-flight instructions.

## Interface
- ADDR_W, 64, PC/address width
- INST_W, 32, instruction width
- RESET_PC, 64'h0, PC value loaded on reset
- QDEPTH, 4, instruction queue entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- reset  in  1  reset; one clock, synchronous, active-high
- br_taken  in  1  redirect request from execute
- br_target  in  ADDR_W  redirect address; bits [1:0] ignored and forced to 0
- imem_req  out  1  read request to instruction Memory
- imem_addr  out  ADDR_W  read address, word aligned
- imem_rdata  in  INST_W  read data, valid exactly 1 cycle after imem_req
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  INST_W  head instruction
- inst_pc  out  ADDR_W  address of head instruction
- halted  out  1  fetch stopped on HLT (FETCH_HALT_EN only; else tied 0)

## Operation
- States: IDLE, FETCH, HALTED. Reset → IDLE. IDLE → FETCH unconditionally next cycle. FETCH → HALTED on enqueue of HLT (see Configuration). HALTED → FETCH on br_taken.
- imem_req = (state==FETCH) & !br_taken & (count + inflight < QDEPTH). imem_addr = pc. Each req is accepted; pc <= pc + 4, modulo 2^64 (wraps to 0).
- inflight: 1-bit register, set when req issued, cleared next cycle. Returned word is pushed with its address (pc captured at request) unless killed.
- Pop when inst_valid & inst_ready. Push and pop in the same cycle are allowed; count unchanged.
- Credit rule guarantees no push to a full queue; overflow is impossible by construction.
- Redirect (br_taken=1), highest priority: queue flushed (count=0), pending response marked killed and discarded, pc <= {br_target[63:2],2'b00}, no req this cycle. A pop in that cycle has no further effect. First req at target the next cycle.
- br_taken during IDLE: pc loads target; IDLE→FETCH still occurs.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, count=0, inflight=0, imem_req=0, inst_valid=0, halted=0, imem_addr=RESET_PC, inst_data/inst_pc=0.
- Cycle 0 after reset release: IDLE. Cycle 1: first imem_req at RESET_PC. Cycle 2: data pushed. Cycle 3: inst_valid=1.
- Req-to-inst_valid latency: 2 cycles. Redirect-to-inst_valid at target: 3 cycles.
- Sustained throughput 1 instruction/cycle with inst_ready held high.
- inst_ready low: reqs continue until count+inflight=QDEPTH, then stall; resume the cycle after a pop.
- reset mid-operation overrides everything; queue contents and in-flight response discarded.

## Configuration
- FETCH_HALT_EN defined: a pushed word equal to 32'hD4400000 (HLT) is enqueued normally, then state → HALTED, halted=1, no further reqs. A response already in flight is discarded. br_taken resumes at br_target and clears halted.
- Undefined: HLT treated as an ordinary instruction, HALTED unreachable, halted tied 0.

## Structure
- fetch_pkg: ADDR_W, INST_W defaults, HLT_ENC constant, state enum fetch_state_t {IDLE, FETCH, HALTED}, PC_STEP=4.
- Sub-module fetch_queue: QDEPTH-entry FIFO of {pc, inst} with push, pop, synchronous flush, count output. Flush has priority over push/pop.

## Test plan
- Reset release, inst_ready=1, memory returns word = addr>>2: inst_pc 0,4,8,… on consecutive cycles from cycle 3; inst_data 0,1,2,….
- inst_ready=0 for 10 cycles: exactly QDEPTH(4) reqs issued then imem_req=0; raise ready → 4 buffered drain in order, new req the cycle after first pop.
- br_taken with br_target=64'h1003 while queue holds 3 and one in flight: inst_valid=0 next cycle, stale word dropped, next inst_pc=64'h1000 after 3 cycles.
- PC near top: br_target=64'hFFFF_FFFF_FFFF_FFF8: inst_pc …FFF8, …FFFC, 0x0, 0x4.
- FETCH_HALT_EN, HLT at 0x8: instructions 0,4,8 delivered, halted=1, no req after; br_taken to 0x40 → halted=0, fetch resumes at 0x40.
- Assert reset with queue full and br_taken=1: next cycle all outputs at reset values, pc=RESET_PC.
